// File: rtl/reg_file_direct.sv
// Register-file storage stage behind the AXI4-Lite register slave.
// Holds NUM_REGISTERS registers. Each register takes bus writes, hardware overwrites or
// sticky sets. Collisions between bus and hardware writes are resolved with fixed
// precedence, and each one is counted in a saturating counter.
module reg_file_direct #(
  parameter int unsigned NUM_REGISTERS      = 16,
  parameter int unsigned REGISTER_WIDTH     = 32,
  parameter logic [NUM_REGISTERS*REGISTER_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [NUM_REGISTERS-1:0] BUS_WRITABLE = '1,
  parameter logic [NUM_REGISTERS-1:0] HW_STICKY    = '0,
  parameter int unsigned CONFLICT_CNT_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_REGISTERS-1:0]                  i_bus_write_req,
  input  logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]   i_bus_write_data,
  input  logic [NUM_REGISTERS-1:0]                  i_hw_write_en,
  input  logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]   i_hw_write_data,
  input  logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]   i_hw_set,
  output logic [NUM_REGISTERS*REGISTER_WIDTH-1:0]   o_read_data,
  output logic [NUM_REGISTERS-1:0]                  o_bus_update,
  output logic [NUM_REGISTERS-1:0]                  o_bus_rejected,
  output logic [CONFLICT_CNT_WIDTH-1:0]             o_conflict_cnt
);

  localparam int unsigned PopW = $clog2(NUM_REGISTERS + 1);
  // The sum is wide enough to hold a saturated count plus a full popcount without overflow.
  localparam int unsigned SumW = CONFLICT_CNT_WIDTH + PopW;
  localparam logic [CONFLICT_CNT_WIDTH-1:0] CntMax = '1;

  logic [NUM_REGISTERS*REGISTER_WIDTH-1:0] data_q, data_d;
  logic [NUM_REGISTERS-1:0]                bus_update_q, bus_update_d;
  logic [NUM_REGISTERS-1:0]                bus_rejected_q, bus_rejected_d;
  logic [CONFLICT_CNT_WIDTH-1:0]           conflict_cnt_q, conflict_cnt_d;
  logic [NUM_REGISTERS-1:0]                collision;
  logic [REGISTER_WIDTH-1:0]               sticky_base;
  logic [PopW-1:0]                         coll_pop;
  logic [SumW-1:0]                         cnt_sum;

  // Per-register next value, pulse generation and collision detection.
  always_comb begin
    data_d         = data_q;
    bus_update_d   = '0;
    bus_rejected_d = '0;
    collision      = '0;
    sticky_base    = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      if (HW_STICKY[i]) begin
        // Set bits are OR-ed in after the bus write. A same-cycle clear cannot lose an event.
        sticky_base = data_q[i*REGISTER_WIDTH +: REGISTER_WIDTH];
        if (i_bus_write_req[i]) begin
          if (BUS_WRITABLE[i]) begin
            sticky_base     = i_bus_write_data[i*REGISTER_WIDTH +: REGISTER_WIDTH];
            bus_update_d[i] = 1'b1;
            collision[i]    = |i_hw_set[i*REGISTER_WIDTH +: REGISTER_WIDTH];
          end else begin
            bus_rejected_d[i] = 1'b1;
          end
        end
        data_d[i*REGISTER_WIDTH +: REGISTER_WIDTH] =
            sticky_base | i_hw_set[i*REGISTER_WIDTH +: REGISTER_WIDTH];
      end else if (i_hw_write_en[i]) begin
        // A hardware overwrite takes precedence over a same-cycle bus write.
        data_d[i*REGISTER_WIDTH +: REGISTER_WIDTH] =
            i_hw_write_data[i*REGISTER_WIDTH +: REGISTER_WIDTH];
        if (i_bus_write_req[i]) begin
          bus_rejected_d[i] = 1'b1;
          collision[i]      = 1'b1;
        end
      end else if (i_bus_write_req[i]) begin
        if (BUS_WRITABLE[i]) begin
          data_d[i*REGISTER_WIDTH +: REGISTER_WIDTH] =
              i_bus_write_data[i*REGISTER_WIDTH +: REGISTER_WIDTH];
          bus_update_d[i] = 1'b1;
        end else begin
          bus_rejected_d[i] = 1'b1;
        end
      end
    end
  end

  // Saturating collision counter: adds the number of colliding registers each cycle.
  always_comb begin
    coll_pop = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      coll_pop = coll_pop + PopW'(collision[i]);
    end
    cnt_sum = SumW'(conflict_cnt_q) + SumW'(coll_pop);
    if (cnt_sum > SumW'(CntMax)) begin
      conflict_cnt_d = CntMax;
    end else begin
      conflict_cnt_d = cnt_sum[CONFLICT_CNT_WIDTH-1:0];
    end
  end

  // State registers. The synchronous reset overrides every simultaneous request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q         <= RESET_VALUE;
      bus_update_q   <= '0;
      bus_rejected_q <= '0;
      conflict_cnt_q <= '0;
    end else begin
      data_q         <= data_d;
      bus_update_q   <= bus_update_d;
      bus_rejected_q <= bus_rejected_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign o_read_data    = data_q;
  assign o_bus_update   = bus_update_q;
  assign o_bus_rejected = bus_rejected_q;
  assign o_conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_reg_file_direct.sv
// Testbench for reg_file_direct. A per-register behavioural model is checked against
// the DUT on every cycle. Directed literal expectations cover the key scenarios.
module tb_reg_file_direct;

  localparam int NR = 16;
  localparam int RW = 32;
  localparam int CW = 4;
  localparam int FW = NR * RW;
  localparam logic [FW-1:0] RV = FW'(32'hDEADBEEF) << (3 * RW);
  localparam logic [NR-1:0] BW = 16'hFFFD;
  localparam logic [NR-1:0] HS = 16'h0080;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] bus_req;
  logic [FW-1:0] bus_data;
  logic [NR-1:0] hw_en;
  logic [FW-1:0] hw_data;
  logic [FW-1:0] hw_set;
  logic [FW-1:0] read_data;
  logic [NR-1:0] bus_update;
  logic [NR-1:0] bus_rejected;
  logic [CW-1:0] conflict_cnt;

  int tests = 0;
  int fails = 0;

  reg_file_direct #(
    .NUM_REGISTERS     (NR),
    .REGISTER_WIDTH    (RW),
    .RESET_VALUE       (RV),
    .BUS_WRITABLE      (BW),
    .HW_STICKY         (HS),
    .CONFLICT_CNT_WIDTH(CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_bus_write_req (bus_req),
    .i_bus_write_data(bus_data),
    .i_hw_write_en   (hw_en),
    .i_hw_write_data (hw_data),
    .i_hw_set        (hw_set),
    .o_read_data     (read_data),
    .o_bus_update    (bus_update),
    .o_bus_rejected  (bus_rejected),
    .o_conflict_cnt  (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference state
  logic [RW-1:0] m_reg [NR];
  logic [NR-1:0] m_upd;
  logic [NR-1:0] m_rej;
  int            m_cnt;
  bit            m_valid = 1'b0;
  logic [FW-1:0] rv_v;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The model advances on each rising edge using the inputs held stable since the last falling edge.
  always @(posedge clk) begin : model
    logic [RW-1:0] bus_w;
    logic [RW-1:0] set_w;
    int            ncoll;
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_reg[i] = rv_v[i*RW +: RW];
      m_upd   = '0;
      m_rej   = '0;
      m_cnt   = 0;
      m_valid = 1'b1;
    end else begin
      ncoll = 0;
      m_upd = '0;
      m_rej = '0;
      for (int i = 0; i < NR; i++) begin
        bus_w = bus_data[i*RW +: RW];
        set_w = hw_set[i*RW +: RW];
        if (HS[i]) begin
          if (bus_req[i] && BW[i]) begin
            m_reg[i] = bus_w | set_w;
            m_upd[i] = 1'b1;
            if (set_w != 0) ncoll++;
          end else begin
            m_reg[i] = m_reg[i] | set_w;
            if (bus_req[i]) m_rej[i] = 1'b1;
          end
        end else if (hw_en[i]) begin
          m_reg[i] = hw_data[i*RW +: RW];
          if (bus_req[i]) begin
            m_rej[i] = 1'b1;
            ncoll++;
          end
        end else if (bus_req[i]) begin
          if (BW[i]) begin
            m_reg[i] = bus_w;
            m_upd[i] = 1'b1;
          end else begin
            m_rej[i] = 1'b1;
          end
        end
      end
      m_cnt = (m_cnt + ncoll > 15) ? 15 : m_cnt + ncoll;
    end
  end

  // Compare the DUT against the model on every falling edge once the model is initialised.
  always @(negedge clk) begin : compare
    logic [FW-1:0] exp_flat;
    if (m_valid) begin
      for (int i = 0; i < NR; i++) exp_flat[i*RW +: RW] = m_reg[i];
      chk("model_read_data", read_data, exp_flat);
      chk("model_bus_update", FW'(bus_update), FW'(m_upd));
      chk("model_bus_rejected", FW'(bus_rejected), FW'(m_rej));
      chk("model_conflict_cnt", FW'(conflict_cnt), FW'(m_cnt));
    end
  end

  task automatic idle_inputs();
    bus_req  = '0;
    bus_data = '0;
    hw_en    = '0;
    hw_data  = '0;
    hw_set   = '0;
  endtask

  function automatic logic [RW-1:0] rd(input int idx);
    return read_data[idx*RW +: RW];
  endfunction

  initial begin
    rv_v  = RV;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("reset_reg3", FW'(rd(3)), FW'(32'hDEADBEEF));
    chk("reset_all", read_data, rv_v);
    chk("reset_cnt", FW'(conflict_cnt), '0);
    chk("reset_pulses", FW'({bus_update, bus_rejected}), '0);

    // Plain bus write
    bus_req[2] = 1'b1;
    bus_data[2*RW +: RW] = 32'h12345678;
    @(negedge clk);
    idle_inputs();
    chk("bus_wr_reg2", FW'(rd(2)), FW'(32'h12345678));
    chk("bus_wr_upd2", FW'(bus_update), FW'(16'h0004));
    @(negedge clk);
    chk("bus_wr_upd_one_cycle", FW'(bus_update), '0);

    // Hardware overwrite wins over the bus on a non-sticky register
    bus_req[5] = 1'b1;
    bus_data[5*RW +: RW] = 32'h1111;
    hw_en[5] = 1'b1;
    hw_data[5*RW +: RW] = 32'h2222;
    @(negedge clk);
    idle_inputs();
    chk("coll_reg5", FW'(rd(5)), FW'(32'h2222));
    chk("coll_rej5", FW'(bus_rejected), FW'(16'h0020));
    chk("coll_upd5", FW'(bus_update), '0);
    chk("coll_cnt1", FW'(conflict_cnt), FW'(4'd1));

    // Sticky register 7
    bus_req[7] = 1'b1;
    bus_data[7*RW +: RW] = 32'h0F;
    @(negedge clk);
    idle_inputs();
    hw_set[7*RW +: RW] = 32'h30;
    hw_en[7] = 1'b1;
    hw_data[7*RW +: RW] = 32'hFFFF_FFFF;
    @(negedge clk);
    idle_inputs();
    chk("sticky_set", FW'(rd(7)), FW'(32'h3F));
    bus_req[7] = 1'b1;
    bus_data[7*RW +: RW] = 32'h0;
    hw_set[7*RW +: RW] = 32'h40;
    @(negedge clk);
    idle_inputs();
    chk("sticky_clear_set", FW'(rd(7)), FW'(32'h40));
    chk("sticky_upd7", FW'(bus_update), FW'(16'h0080));
    chk("sticky_cnt2", FW'(conflict_cnt), FW'(4'd2));

    // Bus write to a read-only register
    bus_req[1] = 1'b1;
    bus_data[1*RW +: RW] = 32'hFFFF;
    @(negedge clk);
    idle_inputs();
    chk("ro_reg1", FW'(rd(1)), '0);
    chk("ro_rej1", FW'(bus_rejected), FW'(16'h0002));
    chk("ro_cnt", FW'(conflict_cnt), FW'(4'd2));

    // Saturation: 20 single collisions, then 3 collisions in the same cycle
    for (int k = 0; k < 20; k++) begin
      bus_req[5] = 1'b1;
      hw_en[5] = 1'b1;
      hw_data[5*RW +: RW] = 32'(k);
      @(negedge clk);
    end
    chk("sat_after_singles", FW'(conflict_cnt), FW'(4'hF));
    bus_req = 16'h0070;
    hw_en = 16'h0070;
    @(negedge clk);
    chk("sat_after_triple", FW'(conflict_cnt), FW'(4'hF));
    // Reset while the collision burst is still being driven
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_cnt", FW'(conflict_cnt), '0);
    chk("rst_mid_regs", read_data, rv_v);
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < NR; i++) begin
        bus_req[i] = ($urandom_range(0, 3) == 0);
        hw_en[i]   = ($urandom_range(0, 3) == 0);
        bus_data[i*RW +: RW] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        hw_data[i*RW +: RW]  = $urandom;
        hw_set[i*RW +: RW]   = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
